can_rx_bit_ctrl: RTL
====================

Name: can_rx_bit_ctrl

Overview:
- Receive-side bit-timing and sequencing controller for the CAN 2.0 RX path.
- Synchronizes raw can_rx and integrates onto the bus by waiting for 11 recessive bits.
- Hard-syncs on SOF, soft-resyncs on recessive-to-dominant edges within SJW, and issues one sample strobe per bit at the programmed sample point.
- Removes stuff bits and flags stuff errors. Feeds the downstream frame parser, which returns stuff_en and frame_done.

Parameters:
- CLK_FREQ_MHZ, 100, system clock frequency in MHz.
- BIT_RATE_KBITS, 1000, CAN bit rate in kbit/s. PERIOD = CLK_FREQ_MHZ*1000/BIT_RATE_KBITS clocks per bit (100 at defaults).
- SAMPLE_PCT, 75, sample point as a percent of the bit. SP = PERIOD*SAMPLE_PCT/100 (75 at defaults).
- SJW, 20, resync jump width in clocks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- can_rx  in  1  raw bus line, asynchronous (0 = dominant)
- stuff_en  in  1  parser: destuffing active (high SOF..CRC)
- frame_done  in  1  parser: single-cycle pulse, frame complete
- sample_valid  out  1  single-cycle pulse, new destuffed bit
- sample_bit  out  1  bit value, held until next sample_valid
- stuff_drop  out  1  single-cycle pulse, stuff bit removed
- stuff_err  out  1  single-cycle pulse, stuff rule violated
- bus_idle  out  1  high only in IDLE
- frame_active  out  1  high only in ACTIVE
- bit_cnt  out  8  destuffed bits emitted this frame, saturates at 255

Behaviour:
- Reset (async, any time incl. mid-frame):
  - state=INTEG; cnt=0; counters=0.
  - All outputs 0 except sample_bit=1.
  - Synchronizer flops are set to 1.
- Synchronizer: 2-FF (ff1, ff2) plus history flop ff3. Falling edge = ff3 & ~ff2.
- Bit counter cnt (0..PERIOD-1):
  - Free-running, wraps PERIOD-1 -> 0.
  - Sample event = cycle with cnt==SP.
  - All outputs are registered and appear the cycle after the sample event.
- Hard sync (IDLE falling edge): cnt=0 next cycle.
  - If the input falls and is captured by ff1 at edge k, the SOF sample_valid asserts at edge k+78 at defaults.
- Soft resync (ACTIVE falling edge, at most one per bit, ignored when cnt==0):
  - 1 <= cnt <= SP:
    - cnt <= SJW: cnt <= 0.
    - otherwise: cnt <= cnt-SJW.
  - cnt > SP:
    - cnt >= PERIOD-SJW: cnt <= 0.
    - otherwise: cnt <= cnt+SJW.
- States:
  - INTEG:
    - rec_cnt increments on each recessive sample and clears on a dominant sample.
    - rec_cnt==11 -> IDLE.
    - No sample_valid is emitted.
  - IDLE:
    - bus_idle=1.
    - Falling edge -> hard sync -> ACTIVE.
    - bit_cnt=0; same_cnt=0.
  - ACTIVE:
    - First sample recessive (glitch): no outputs, -> IDLE.
    - Otherwise each sample is emitted (sample_valid, sample_bit, bit_cnt+1).
    - same_cnt tracks consecutive equal samples, resetting to 1 on a value change; SOF counts as 1.
    - When stuff_en=1 and same_cnt==5:
      - next sample differs: stuff_drop, no sample_valid, bit_cnt unchanged, same_cnt=1 with the new value;
      - next sample equals: stuff_err, -> INTEG.
    - stuff_en=0: no stuff handling.
    - frame_done -> INTEG.
- Simultaneous events:
  - A sample event in the same cycle as frame_done is still emitted.
  - stuff_err and frame_done together: stuff_err is asserted; next state is INTEG either way.
  - frame_done outside ACTIVE is ignored.
  - stuff_en changes take effect at the next sample event.

Test Plan:
1. Reset with can_rx=1 -> bus_idle rises after 11 sample events (~1100 clocks). No sample_valid before that.
2. stuff_en=1; send 0000011000001 from IDLE:
   - sample_valid on bits 1-5 (value 0, bit_cnt=5);
   - 6th bit (1) -> stuff_drop, bit_cnt stays 5;
   - 7th bit (1) -> sample_valid, bit_cnt=6.
3. stuff_en=1; six consecutive dominant bits from SOF -> stuff_err pulse on the 6th sample, frame_active=0, bus_idle=0. bus_idle=1 again 11 bit periods after the line returns recessive.
4. Resync during ACTIVE:
   - bit edge delayed 10 clocks -> next sample_valid exactly 10 clocks later than nominal;
   - edge delayed 40 clocks -> cnt reduced by 20, next sample 20 clocks later.
5. In IDLE, 20-clock dominant glitch -> no sample_valid, state returns to IDLE (bus_idle=1) after the SP sample event.
6. frame_done pulse mid-ACTIVE, then 11 recessive bits -> bus_idle=1. Assert rst_n=0 mid-frame -> all outputs reset immediately without waiting for clk.

Source files
------------

// File: rtl/can_rx_bit_ctrl_if.sv
// rtl/can_rx_bit_ctrl_if.sv - bus line and parser handshake between the CAN RX bit controller and the frame parser
interface can_rx_bit_ctrl_if;
    logic       can_rx;
    logic       stuff_en;
    logic       frame_done;
    logic       sample_valid;
    logic       sample_bit;
    logic       stuff_drop;
    logic       stuff_err;
    logic       bus_idle;
    logic       frame_active;
    logic [7:0] bit_cnt;

    // Parser / line side: drives the raw bus and parser feedback, consumes destuffed bits
    modport master (
        output can_rx,
        output stuff_en,
        output frame_done,
        input  sample_valid,
        input  sample_bit,
        input  stuff_drop,
        input  stuff_err,
        input  bus_idle,
        input  frame_active,
        input  bit_cnt
    );

    // Bit controller side
    modport slave (
        input  can_rx,
        input  stuff_en,
        input  frame_done,
        output sample_valid,
        output sample_bit,
        output stuff_drop,
        output stuff_err,
        output bus_idle,
        output frame_active,
        output bit_cnt
    );
endinterface

// File: rtl/can_rx_bit_ctrl.sv
// rtl/can_rx_bit_ctrl.sv - CAN RX bit timing, bus integration, resync and destuffing controller
module can_rx_bit_ctrl #(
    parameter int CLK_FREQ_MHZ   = 100,
    parameter int BIT_RATE_KBITS = 1000,
    parameter int SAMPLE_PCT     = 75,
    parameter int SJW            = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    can_rx_bit_ctrl_if.slave bus
);
    localparam int PERIOD = CLK_FREQ_MHZ * 1000 / BIT_RATE_KBITS;
    localparam int SP     = PERIOD * SAMPLE_PCT / 100;
    localparam int CW     = $clog2(PERIOD);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t SP_C      = cnt_t'(SP);
    localparam cnt_t PERIOD_M1 = cnt_t'(PERIOD - 1);
    localparam cnt_t SJW_C     = cnt_t'(SJW);
    localparam cnt_t LATE_LIM  = cnt_t'(PERIOD - SJW);
    localparam cnt_t ONE_C     = cnt_t'(1);
    localparam logic [3:0] REC_LAST = 4'd10;

    typedef enum logic [1:0] {
        S_INTEG  = 2'd0,
        S_IDLE   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic       ff1, ff2, ff3;
    cnt_t       cnt, cnt_n;
    logic       resynced;
    logic       resync;
    logic [3:0] rec_cnt, rec_n;
    logic [2:0] same_cnt, same_n;
    logic       last_bit, last_n;
    logic       sof_pend, sof_n;
    logic [7:0] bit_cnt_q, bcnt_n;
    logic [7:0] bcnt_inc;
    logic       valid_q, valid_n;
    logic       sbit_q, sbit_n;
    logic       drop_q, drop_n;
    logic       err_q, err_n;

    logic fall;
    logic rx_s;
    logic sample_evt;

    assign fall       = ff3 & ~ff2;
    assign rx_s       = ff2;
    assign sample_evt = (cnt == SP_C);
    assign bcnt_inc   = (bit_cnt_q == 8'hFF) ? bit_cnt_q : bit_cnt_q + 8'd1;

    assign bus.sample_valid = valid_q;
    assign bus.sample_bit   = sbit_q;
    assign bus.stuff_drop   = drop_q;
    assign bus.stuff_err    = err_q;
    assign bus.bit_cnt      = bit_cnt_q;
    assign bus.bus_idle     = (state == S_IDLE);
    assign bus.frame_active = (state == S_ACTIVE);

    // Two-stage synchronizer plus history flop for falling-edge detection; idles recessive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= 1'b1;
            ff2 <= 1'b1;
            ff3 <= 1'b1;
        end else begin
            ff1 <= bus.can_rx;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    // Bit-phase counter: free-running, hard sync from IDLE, one bounded phase correction per bit
    always_comb begin
        cnt_n  = (cnt == PERIOD_M1) ? '0 : cnt + ONE_C;
        resync = 1'b0;
        if (state == S_IDLE && fall) begin
            cnt_n = '0;
        end else if (state == S_ACTIVE && fall && cnt != '0 && !resynced) begin
            resync = 1'b1;
            if (cnt <= SP_C) begin
                // Edge arrived late: stretch this bit by up to SJW clocks
                if (cnt <= SJW_C) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + ONE_C - SJW_C;
                end
            end else begin
                // Edge arrived early for the next bit: shorten by up to SJW clocks
                if (cnt >= LATE_LIM) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + SJW_C;
                end
            end
        end
    end

    // Phase counter and the once-per-bit resync lockout, rearmed at each sample point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            resynced <= 1'b0;
        end else begin
            cnt <= cnt_n;
            if (resync) begin
                resynced <= 1'b1;
            end else if (sample_evt || state != S_ACTIVE) begin
                resynced <= 1'b0;
            end
        end
    end

    // Sequencing: integration, idle wait, and per-sample emit/destuff decisions
    always_comb begin
        state_n = state;
        rec_n   = rec_cnt;
        same_n  = same_cnt;
        last_n  = last_bit;
        sof_n   = sof_pend;
        bcnt_n  = bit_cnt_q;
        valid_n = 1'b0;
        sbit_n  = sbit_q;
        drop_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_INTEG: begin
                if (sample_evt) begin
                    if (rx_s) begin
                        if (rec_cnt == REC_LAST) begin
                            state_n = S_IDLE;
                            rec_n   = '0;
                        end else begin
                            rec_n = rec_cnt + 4'd1;
                        end
                    end else begin
                        rec_n = '0;
                    end
                end
            end
            S_IDLE: begin
                if (fall) begin
                    state_n = S_ACTIVE;
                    sof_n   = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (sample_evt) begin
                    if (sof_pend) begin
                        sof_n = 1'b0;
                        if (rx_s) begin
                            // Recessive at the SOF sample point: the edge was a glitch
                            state_n = S_IDLE;
                        end else begin
                            valid_n = 1'b1;
                            sbit_n  = 1'b0;
                            bcnt_n  = bcnt_inc;
                            same_n  = 3'd1;
                            last_n  = 1'b0;
                        end
                    end else if (bus.stuff_en && same_cnt == 3'd5) begin
                        if (rx_s != last_bit) begin
                            drop_n = 1'b1;
                            same_n = 3'd1;
                            last_n = rx_s;
                        end else begin
                            err_n   = 1'b1;
                            state_n = S_INTEG;
                        end
                    end else begin
                        valid_n = 1'b1;
                        sbit_n  = rx_s;
                        bcnt_n  = bcnt_inc;
                        last_n  = rx_s;
                        if (rx_s != last_bit) begin
                            same_n = 3'd1;
                        end else if (same_cnt != 3'd7) begin
                            same_n = same_cnt + 3'd1;
                        end
                    end
                end
                if (bus.frame_done) begin
                    state_n = S_INTEG;
                end
            end
            default: state_n = S_INTEG;
        endcase
        if (state_n == S_INTEG && state != S_INTEG) begin
            rec_n = '0;
        end
        if (state_n == S_IDLE) begin
            bcnt_n = '0;
            same_n = '0;
            sof_n  = 1'b0;
        end
    end

    // State register plus registered outputs and per-frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INTEG;
            rec_cnt   <= '0;
            same_cnt  <= '0;
            last_bit  <= 1'b1;
            sof_pend  <= 1'b0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            sbit_q    <= 1'b1;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            rec_cnt   <= rec_n;
            same_cnt  <= same_n;
            last_bit  <= last_n;
            sof_pend  <= sof_n;
            bit_cnt_q <= bcnt_n;
            valid_q   <= valid_n;
            sbit_q    <= sbit_n;
            drop_q    <= drop_n;
            err_q     <= err_n;
        end
    end
endmodule
